// File: rtl/memd_resp.sv
// ============================================================================
//  Module   : memd_resp
//  Brief    : Single-outstanding memory responder with fixed-latency replies,
//             flush and valid/ready handshakes. Writes enabled by MEMD_RESP_WR_EN.
//  Revision : 1.0
// ============================================================================
`ifndef MEMD_SIZE_LOG
`define MEMD_SIZE_LOG 4
`endif
`ifndef REG_LEN
`define REG_LEN 16
`endif

`default_nettype none

module memd_resp #(
  parameter int LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [`MEMD_SIZE_LOG-1:0] req_addr,
  input  logic                      req_we,
  input  logic [`REG_LEN-1:0]       req_wdata,
  input  logic                      flush,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [`REG_LEN-1:0]       resp_data
);

  localparam int AW    = `MEMD_SIZE_LOG;
  localparam int DW    = `REG_LEN;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  mem_q [DEPTH];
  logic           accept;
  logic           wr_en;

  assign accept = req_valid && (state_q == IDLE);

`ifdef MEMD_RESP_WR_EN
  assign wr_en = accept && req_we;
`else
  logic unused_we;
  assign unused_we = req_we;
  assign wr_en     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = wr_en ? req_wdata : mem_q[req_addr];
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          // resp_valid is first seen by the requester on the LATENCY-th edge
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RESP;
        end
      end
      RESP: begin
        if (flush || resp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DW'(i);
    end else if (wr_en) begin
      mem_q[req_addr] <= req_wdata;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_memd_resp.sv
// ============================================================================
//  Module   : tb_memd_resp
//  Brief    : Self-checking bench for memd_resp (LATENCY=2 and LATENCY=1 instances).
//  Revision : 1.0
// ============================================================================
`ifndef MEMD_SIZE_LOG
`define MEMD_SIZE_LOG 4
`endif
`ifndef REG_LEN
`define REG_LEN 16
`endif

`default_nettype none

module tb_memd_resp;

  localparam int AW    = `MEMD_SIZE_LOG;
  localparam int DW    = `REG_LEN;
  localparam int DEPTH = 1 << AW;
  localparam int LAT   = 2;
`ifdef MEMD_RESP_WR_EN
  localparam bit WR = 1'b1;
`else
  localparam bit WR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, flush = 1'b0, resp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, resp_valid;
  logic [DW-1:0] resp_data;

  logic          v1 = 1'b0, we1 = 1'b0, fl1 = 1'b0, rr1 = 1'b0;
  logic [AW-1:0] a1 = '0;
  logic [DW-1:0] wd1 = '0;
  logic          rdy1, rv1;
  logic [DW-1:0] rd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memd_resp #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
  );

  memd_resp #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
    .req_addr(a1), .req_we(we1), .req_wdata(wd1), .flush(fl1),
    .resp_valid(rv1), .resp_ready(rr1), .resp_data(rd1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One request on dut, response held for 'hold' cycles before resp_ready.
  task automatic txn(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                     input logic [DW-1:0] exp, input int hold, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, "_ready_before"}, req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      chk({nm, "_ready_busy"}, req_ready, 0);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, LAT);
    for (int h = 0; h < hold; h++) begin
      chk({nm, "_hold_valid"}, resp_valid, 1);
      chk({nm, "_hold_data"}, resp_data, exp);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    chk({nm, "_valid"}, resp_valid, 1);
    chk({nm, "_data"}, resp_data, exp);
    chk({nm, "_ready_in_resp"}, req_ready, 0);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, "_valid_after"}, resp_valid, 0);
    chk({nm, "_ready_after"}, req_ready, 1);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  logic [DW-1:0] mem_m [DEPTH];
  logic          busy, exp_v;
  int            age;
  logic [DW-1:0] exp_d;

  initial begin
    vecs[0] = '{addr: 5,  we: 0, wdata: 0,       exp: 5};
    vecs[1] = '{addr: 3,  we: 1, wdata: 'hAB,    exp: WR ? DW'('hAB) : DW'(3)};
    vecs[2] = '{addr: 3,  we: 0, wdata: 0,       exp: WR ? DW'('hAB) : DW'(3)};
    vecs[3] = '{addr: 0,  we: 0, wdata: 0,       exp: 0};
    vecs[4] = '{addr: AW'(DEPTH-1), we: 1, wdata: 'h1234, exp: WR ? DW'('h1234) : DW'(DEPTH-1)};
    vecs[5] = '{addr: AW'(DEPTH-1), we: 0, wdata: 0, exp: WR ? DW'('h1234) : DW'(DEPTH-1)};
    vecs[6] = '{addr: 1,  we: 0, wdata: 0,       exp: 1};

    // Reset values while rst_n is held low
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].exp, 0, $sformatf("vec%0d", i));

    // Backpressure: response held while resp_ready low
    txn(7, 0, 0, 7, 4, "hold7");

    // Flush during WAIT
    @(negedge clk);
    req_valid = 1'b1; req_addr = 2; req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1; resp_ready = 1'b1;
    chk("flush_inwait_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", req_ready, 1);
    chk("flush_valid", resp_valid, 0);
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_resp", resp_valid, 0);
    end
    resp_ready = 1'b0;
    txn(4, 0, 0, 4, 0, "after_flush");

    // Asynchronous reset during WAIT
    @(negedge clk);
    req_valid = 1'b1; req_addr = 9; req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready, 1);
    chk("arst_valid", resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("arst_no_resp", resp_valid, 0);
      chk("arst_ready_after", req_ready, 1);
    end
    txn(9, 0, 0, 9, 0, "after_rst");

    // LATENCY=1 back-to-back: responses every second cycle, no accept on handshake edge
    @(negedge clk);
    v1 = 1'b1; rr1 = 1'b1; a1 = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("b2b_valid", rv1, (n % 2) == 1);
      chk("b2b_ready", rdy1, (n % 2) == 0);
      if ((n % 2) == 1) chk("b2b_data", rd1, DW'(n - 1));
      a1 = AW'(n);
    end
    v1 = 1'b0; rr1 = 1'b0;

    // Randomized traffic against a transaction-level model (memory starts at reset contents)
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = DW'(i);
    busy = 1'b0; age = 0; exp_d = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp_v = busy && (age >= LAT);
      chk("rnd_ready", req_ready, !busy);
      chk("rnd_valid", resp_valid, exp_v);
      if (exp_v) chk("rnd_data", resp_data, exp_d);
      req_valid  = ($urandom_range(0, 2) != 0);
      req_addr   = AW'($urandom);
      req_we     = 1'($urandom);
      req_wdata  = DW'($urandom);
      flush      = ($urandom_range(0, 9) == 0);
      resp_ready = 1'($urandom);
      if (!busy) begin
        if (req_valid) begin
          busy = 1'b1;
          age  = 1;
          if (WR && req_we) begin
            exp_d = req_wdata;
            mem_m[req_addr] = req_wdata;
          end else begin
            exp_d = mem_m[req_addr];
          end
        end
      end else if (flush || (exp_v && resp_ready)) begin
        busy = 1'b0;
      end else begin
        age++;
      end
    end
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
